audio_sample_scheduler: RTL and testbench

- Shares the single-sample stereo input of the 44.1 kHz output block among N_REQ audio sources (synth voices, sample player, test tone).
- Round-robin arbitration grants one source per output sample slot.
- Drives the output block's wreq/sample and obeys its ready handshake.
- Counts slots that pass with no sample delivered (underruns).

---
 rtl/audio_sample_scheduler_if.sv | 50 +++++
 rtl/audio_sample_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_audio_sample_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/audio_sample_scheduler_if.sv
// Bus between the audio sample scheduler, its N_REQ sources and the
// 44.1 kHz output block. The scheduler attaches through the master modport;
// sources, output block and test benches attach through the slave modport.
// Optional feature macro: AUDIO_SCHED_MUTE_EN (adds mute_mask).
interface audio_sample_scheduler_if #(
  parameter int AUDIO_BITS = 12,
  parameter int N_REQ      = 4,
  parameter int ID_BITS    = 2
);
  // Source side
  logic [N_REQ-1:0]              req;
  logic [N_REQ*2*AUDIO_BITS-1:0] req_sample;
  logic [N_REQ-1:0]              ack;
`ifdef AUDIO_SCHED_MUTE_EN
  logic [N_REQ-1:0]              mute_mask;
`endif

  // Output block side
  logic                          out_ready;
  logic                          out_wreq;
  logic [2*AUDIO_BITS-1:0]       out_sample;

  // Status
  logic [ID_BITS-1:0]            grant_id;
  logic                          busy;
  logic [15:0]                   underrun_cnt;
  logic                          proto_err;

`ifdef AUDIO_SCHED_MUTE_EN
  modport master (
    input  req, req_sample, mute_mask, out_ready,
    output ack, out_wreq, out_sample, grant_id, busy, underrun_cnt, proto_err
  );

  modport slave (
    output req, req_sample, mute_mask, out_ready,
    input  ack, out_wreq, out_sample, grant_id, busy, underrun_cnt, proto_err
  );
`else
  modport master (
    input  req, req_sample, out_ready,
    output ack, out_wreq, out_sample, grant_id, busy, underrun_cnt, proto_err
  );

  modport slave (
    output req, req_sample, out_ready,
    input  ack, out_wreq, out_sample, grant_id, busy, underrun_cnt, proto_err
  );
`endif
endinterface

// File: rtl/audio_sample_scheduler.sv
// Audio sample scheduler: shares the single stereo sample input of the
// 44.1 kHz output block among N_REQ sources with round-robin arbitration,
// one grant per output slot, and counts slots that pass without a sample.
// Optional feature macro: AUDIO_SCHED_MUTE_EN -- when defined, a source whose
// mute_mask bit is set at the deciding edge is granted and acked as usual but
// its sample is replaced by all-zeros on out_sample.
module audio_sample_scheduler #(
  parameter int AUDIO_BITS  = 12,
  parameter int N_REQ       = 4,
  parameter int ID_BITS     = 2,
  parameter int SLOT_CYCLES = 4096  // must be >= 2
) (
  input  logic                    clk_audio,
  input  logic                    aclr,
  audio_sample_scheduler_if.master bus
);

  localparam int                   SW           = 2 * AUDIO_BITS;
  localparam int                   SLOT_BITS    = $clog2(SLOT_CYCLES);
  localparam logic [SLOT_BITS-1:0] SLOT_LAST    = SLOT_BITS'(SLOT_CYCLES - 1);
  localparam logic [ID_BITS-1:0]   PTR_RESET    = ID_BITS'(N_REQ - 1);
  localparam logic [15:0]          UNDERRUN_MAX = 16'hFFFF;
  // Edges with out_ready still high while in ISSUE before flagging an error
  localparam logic [1:0]           ISSUE_LAST   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Registered state and outputs
  state_t                 state_q,        state_d;
  logic [ID_BITS-1:0]     rr_ptr_q,       rr_ptr_d;
  logic [SLOT_BITS-1:0]   slot_cnt_q,     slot_cnt_d;
  logic [1:0]             issue_cnt_q,    issue_cnt_d;
  logic [N_REQ-1:0]       ack_q,          ack_d;
  logic                   out_wreq_q,     out_wreq_d;
  logic [SW-1:0]          out_sample_q,   out_sample_d;
  logic [ID_BITS-1:0]     grant_id_q,     grant_id_d;
  logic                   busy_q,         busy_d;
  logic [15:0]            underrun_cnt_q, underrun_cnt_d;
  logic                   proto_err_q,    proto_err_d;

  // Arbitration results for the current cycle
  logic [ID_BITS-1:0]     win_s;
  logic [SW-1:0]          win_sample_s;
  logic [SW-1:0]          grant_sample_s;
`ifdef AUDIO_SCHED_MUTE_EN
  logic                   win_mute_s;
`endif

  // Round-robin pick: first requester strictly above ptr, otherwise the
  // lowest requester at or below ptr (wrap-around).
  function automatic logic [ID_BITS-1:0] rr_pick(
    input logic [N_REQ-1:0]   r,
    input logic [ID_BITS-1:0] ptr
  );
    logic [ID_BITS-1:0] hi_win;
    logic [ID_BITS-1:0] lo_win;
    logic               hi_found;
    logic               lo_found;
    hi_win   = '0;
    lo_win   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r[i] && (i > int'(ptr)) && !hi_found) begin
        hi_win   = ID_BITS'(i);
        hi_found = 1'b1;
      end else if (r[i] && (i <= int'(ptr)) && !lo_found) begin
        lo_win   = ID_BITS'(i);
        lo_found = 1'b1;
      end else begin
        hi_found = hi_found;
      end
    end
    if (hi_found) begin
      return hi_win;
    end else begin
      return lo_win;
    end
  endfunction

  // Winner index and the sample slice it offers at this edge
  always_comb begin
    win_s        = rr_pick(bus.req, rr_ptr_q);
    win_sample_s = '0;
`ifdef AUDIO_SCHED_MUTE_EN
    win_mute_s   = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      win_sample_s = win_sample_s |
                     ((ID_BITS'(i) == win_s) ? bus.req_sample[i*SW +: SW] : {SW{1'b0}});
`ifdef AUDIO_SCHED_MUTE_EN
      win_mute_s   = win_mute_s | ((ID_BITS'(i) == win_s) & bus.mute_mask[i]);
`endif
    end
`ifdef AUDIO_SCHED_MUTE_EN
    grant_sample_s = win_mute_s ? {SW{1'b0}} : win_sample_s;
`else
    grant_sample_s = win_sample_s;
`endif
  end

  // Next-state logic for the slot FSM, underrun counter and all outputs
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    slot_cnt_d     = slot_cnt_q;
    issue_cnt_d    = issue_cnt_q;
    ack_d          = '0;
    out_wreq_d     = 1'b0;
    out_sample_d   = out_sample_q;
    grant_id_d     = grant_id_q;
    underrun_cnt_d = underrun_cnt_q;
    proto_err_d    = proto_err_q;

    case (state_q)
      ST_IDLE: begin
        issue_cnt_d = 2'd0;
        if (bus.out_ready && (|bus.req)) begin
          // Grant: one write request and one ack, issued on the next cycle
          out_wreq_d   = 1'b1;
          for (int i = 0; i < N_REQ; i++) begin
            ack_d[i] = (ID_BITS'(i) == win_s);
          end
          out_sample_d = grant_sample_s;
          grant_id_d   = win_s;
          rr_ptr_d     = win_s;
          slot_cnt_d   = '0;
          state_d      = ST_ISSUE;
        end else if (bus.out_ready) begin
          // Output block is waiting and nobody has a sample for it
          if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            if (underrun_cnt_q != UNDERRUN_MAX) begin
              underrun_cnt_d = underrun_cnt_q + 16'd1;
            end else begin
              underrun_cnt_d = underrun_cnt_q;
            end
          end else begin
            slot_cnt_d = slot_cnt_q + SLOT_BITS'(1);
          end
        end else begin
          slot_cnt_d = slot_cnt_q;
        end
      end

      ST_ISSUE: begin
        slot_cnt_d = '0;
        if (!bus.out_ready) begin
          // Output block has taken the sample
          issue_cnt_d = 2'd0;
          state_d     = ST_DRAIN;
        end else if (issue_cnt_q == ISSUE_LAST) begin
          // Ready never dropped after the write: handshake violation
          issue_cnt_d = 2'd0;
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          issue_cnt_d = issue_cnt_q + 2'd1;
        end
      end

      ST_DRAIN: begin
        slot_cnt_d  = '0;
        issue_cnt_d = 2'd0;
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        slot_cnt_d  = '0;
        issue_cnt_d = 2'd0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; aclr aborts any transfer without an ack
  always_ff @(posedge clk_audio or posedge aclr) begin
    if (aclr) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= PTR_RESET;
      slot_cnt_q     <= '0;
      issue_cnt_q    <= 2'd0;
      ack_q          <= '0;
      out_wreq_q     <= 1'b0;
      out_sample_q   <= '0;
      grant_id_q     <= '0;
      busy_q         <= 1'b0;
      underrun_cnt_q <= 16'd0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      slot_cnt_q     <= slot_cnt_d;
      issue_cnt_q    <= issue_cnt_d;
      ack_q          <= ack_d;
      out_wreq_q     <= out_wreq_d;
      out_sample_q   <= out_sample_d;
      grant_id_q     <= grant_id_d;
      busy_q         <= busy_d;
      underrun_cnt_q <= underrun_cnt_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.out_wreq     = out_wreq_q;
  assign bus.out_sample   = out_sample_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.busy         = busy_q;
  assign bus.underrun_cnt = underrun_cnt_q;
  assign bus.proto_err    = proto_err_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed test bench for audio_sample_scheduler: reset values, first grant,
// round-robin order with wrap, ISSUE timeout error, reset mid-DRAIN,
// underrun counting and saturation, and (with AUDIO_SCHED_MUTE_EN) muting.
module tb_audio_sample_scheduler;

  localparam int AUDIO_BITS  = 12;
  localparam int N_REQ       = 4;
  localparam int ID_BITS     = 2;
  localparam int SLOT_CYCLES = 4096;

  logic clk_audio;
  logic aclr;
  int   total;
  int   bad;

  audio_sample_scheduler_if #(
    .AUDIO_BITS(AUDIO_BITS),
    .N_REQ     (N_REQ),
    .ID_BITS   (ID_BITS)
  ) bus ();

  audio_sample_scheduler #(
    .AUDIO_BITS (AUDIO_BITS),
    .N_REQ      (N_REQ),
    .ID_BITS    (ID_BITS),
    .SLOT_CYCLES(SLOT_CYCLES)
  ) dut (
    .clk_audio(clk_audio),
    .aclr     (aclr),
    .bus      (bus)
  );

  initial clk_audio = 1'b0;
  always #5 clk_audio = ~clk_audio;

  // Advance one clock; outputs are sampled and inputs driven 1 unit after the edge
  task automatic tick();
    @(posedge clk_audio);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full slot from IDLE with ready high: grant, ready drop, ready rise
  task automatic do_slot(input string tag, input logic [1:0] exp_id, input logic [23:0] exp_sample);
    tick();
    check({tag, "_wreq"},   32'(bus.out_wreq),   32'd1);
    check({tag, "_ack"},    32'(bus.ack),        32'(4'b0001 << exp_id));
    check({tag, "_sample"}, 32'(bus.out_sample), 32'(exp_sample));
    check({tag, "_gid"},    32'(bus.grant_id),   32'(exp_id));
    bus.out_ready = 1'b0;
    tick();
    check({tag, "_ack_clr"}, 32'(bus.ack),       32'd0);
    check({tag, "_busy"},    32'(bus.busy),      32'd1);
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_idle"},    32'(bus.busy),      32'd0);
  endtask

  task automatic pulse_reset();
    aclr = 1'b1;
    tick();
    tick();
    aclr = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    aclr  = 1'b1;
    bus.req        = '0;
    bus.req_sample = '0;
    bus.out_ready  = 1'b0;
`ifdef AUDIO_SCHED_MUTE_EN
    bus.mute_mask  = '0;
`endif

    // Reset values
    tick();
    tick();
    check("rst_ack",      32'(bus.ack),          32'd0);
    check("rst_wreq",     32'(bus.out_wreq),     32'd0);
    check("rst_sample",   32'(bus.out_sample),   32'd0);
    check("rst_gid",      32'(bus.grant_id),     32'd0);
    check("rst_busy",     32'(bus.busy),         32'd0);
    check("rst_underrun", 32'(bus.underrun_cnt), 32'd0);
    check("rst_perr",     32'(bus.proto_err),    32'd0);
    aclr = 1'b0;

    // First grant: single source 0, one-cycle latency, then DRAIN and back
    bus.req             = 4'b0001;
    bus.req_sample[23:0] = 24'hABC123;
    bus.out_ready       = 1'b1;
    tick();
    check("t1_wreq",   32'(bus.out_wreq),   32'd1);
    check("t1_ack",    32'(bus.ack),        32'h1);
    check("t1_sample", 32'(bus.out_sample), 32'hABC123);
    check("t1_gid",    32'(bus.grant_id),   32'd0);
    check("t1_busy",   32'(bus.busy),       32'd1);
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    tick();
    check("t1_wreq_clr", 32'(bus.out_wreq), 32'd0);
    check("t1_ack_clr",  32'(bus.ack),      32'd0);
    tick();
    check("t1_drain_wait", 32'(bus.busy),   32'd1);
    check("t1_sample_hold", 32'(bus.out_sample), 32'hABC123);
    bus.out_ready = 1'b1;
    tick();
    check("t1_back_idle", 32'(bus.busy),    32'd0);

    // Round robin with all sources requesting: order 0,1,2,3,0
    pulse_reset();
    bus.req_sample = {24'h400004, 24'h300003, 24'h200002, 24'h100001};
    bus.req        = 4'b1111;
    bus.out_ready  = 1'b1;
    do_slot("rr0", 2'd0, 24'h100001);
    do_slot("rr1", 2'd1, 24'h200002);
    do_slot("rr2", 2'd2, 24'h300003);
    do_slot("rr3", 2'd3, 24'h400004);
    do_slot("rr4", 2'd0, 24'h100001);

    // Wrap: pointer 0 -> grant 1, pointer 1 with 0011 -> 0, then 0011 -> 1
    bus.req = 4'b0010;
    do_slot("wr_a", 2'd1, 24'h200002);
    bus.req = 4'b0011;
    do_slot("wr_b", 2'd0, 24'h100001);
    do_slot("wr_c", 2'd1, 24'h200002);

    // Ready stays high after the write for 4 ISSUE cycles -> proto_err
    bus.req = 4'b0100;
    tick();
    check("pe_gid", 32'(bus.grant_id), 32'd2);
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    check("pe_not_yet", 32'(bus.proto_err), 32'd0);
    check("pe_busy",    32'(bus.busy),      32'd1);
    tick();
    check("pe_set",     32'(bus.proto_err), 32'd1);
    check("pe_idle",    32'(bus.busy),      32'd0);

    // Next grant from pointer 2 goes to 3; proto_err stays sticky
    bus.req = 4'b1000;
    tick();
    check("md_gid",    32'(bus.grant_id),  32'd3);
    check("pe_sticky", 32'(bus.proto_err), 32'd1);
    bus.out_ready = 1'b0;
    tick();
    check("md_drain", 32'(bus.busy), 32'd1);

    // Asynchronous reset in DRAIN clears every output without a clock edge
    aclr = 1'b1;
    #2;
    check("ar_ack",      32'(bus.ack),          32'd0);
    check("ar_wreq",     32'(bus.out_wreq),     32'd0);
    check("ar_sample",   32'(bus.out_sample),   32'd0);
    check("ar_gid",      32'(bus.grant_id),     32'd0);
    check("ar_busy",     32'(bus.busy),         32'd0);
    check("ar_underrun", 32'(bus.underrun_cnt), 32'd0);
    check("ar_perr",     32'(bus.proto_err),    32'd0);
    tick();
    aclr          = 1'b0;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    do_slot("ar_first", 2'd0, 24'h100001);

    // Underruns: one per SLOT_CYCLES idle-ready cycles
    pulse_reset();
    bus.req       = 4'b0000;
    bus.out_ready = 1'b1;
    repeat (SLOT_CYCLES - 1) tick();
    check("ur_edge_0", 32'(bus.underrun_cnt), 32'd0);
    tick();
    check("ur_edge_1", 32'(bus.underrun_cnt), 32'd1);
    repeat (2 * SLOT_CYCLES - 1) tick();
    check("ur_edge_2", 32'(bus.underrun_cnt), 32'd2);
    tick();
    check("ur_three",  32'(bus.underrun_cnt), 32'd3);

    // Saturation: preload 16'hFFFE, then idle three more slots
    force dut.underrun_cnt_q = 16'hFFFE;
    tick();
    release dut.underrun_cnt_q;
    repeat (SLOT_CYCLES - 2) tick();
    check("sat_pre",  32'(bus.underrun_cnt), 32'h0000FFFE);
    tick();
    check("sat_max",  32'(bus.underrun_cnt), 32'h0000FFFF);
    repeat (2 * SLOT_CYCLES) tick();
    check("sat_hold", 32'(bus.underrun_cnt), 32'h0000FFFF);

`ifdef AUDIO_SCHED_MUTE_EN
    // Muted source 2 is acked but delivers zeros
    bus.mute_mask          = 4'b0100;
    bus.req_sample[71:48]  = 24'h123456;
    bus.req                = 4'b0100;
    tick();
    check("mute_ack",    32'(bus.ack),        32'h4);
    check("mute_gid",    32'(bus.grant_id),   32'd2);
    check("mute_sample", 32'(bus.out_sample), 32'h000000);
    bus.req       = 4'b0000;
    bus.mute_mask = 4'b0000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
